reg_writeback_arbiter: RTL and testbench

//  Write-side initiator for the 32x32 register file (drives Reg_Wb/WriteData/Write; file captures on posedge Clk).

---
 rtl/reg_writeback_arbiter_pkg.sv | 21 ++
 rtl/reg_writeback_arbiter_if.sv | 67 ++++++
 rtl/reg_writeback_arbiter_fifo.sv | 61 ++++++
 rtl/reg_writeback_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_writeback_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_writeback_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_writeback_arbiter_pkg                                     |
// | Description : Shared widths, source enum and zero-register constant for the |
// |               register-file write-back arbiter.                             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package reg_writeback_arbiter_pkg;

    localparam int unsigned c_AW = 5;
    localparam int unsigned c_DW = 32;

    localparam logic [c_AW-1:0] c_REG_ZERO = '0;

    typedef enum logic [0:0] {
        SRC_ALU = 1'b0,
        SRC_MDU = 1'b1
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/reg_writeback_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_writeback_arbiter_if                                      |
// | Description : Result, issue, busy-query and write-port signals of the       |
// |               write-back arbiter. Optional macro: WB_BYPASS_EN.             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface reg_writeback_arbiter_if
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int AW = c_AW,
    parameter int DW = c_DW
) ();

    logic          Alu_Valid;
    logic [AW-1:0] Alu_Reg;
    logic [DW-1:0] Alu_Data;

    logic          Mdu_Valid;
    logic          Mdu_Ready;
    logic [AW-1:0] Mdu_Reg;
    logic [DW-1:0] Mdu_Data;

    logic          Issue_Valid;
    logic [AW-1:0] Issue_Reg;

    logic [AW-1:0] Rs;
    logic [AW-1:0] Rt;
    logic          Rs_Busy;
    logic          Rt_Busy;

    logic [AW-1:0] Reg_Wb;
    logic [DW-1:0] WriteData;
    logic          Write;

`ifdef WB_BYPASS_EN
    logic          Fwd_Rs_Hit;
    logic          Fwd_Rt_Hit;
    logic [DW-1:0] Fwd_Data;
`endif

    // Arbiter side
    modport slave (
        input  Alu_Valid, Alu_Reg, Alu_Data,
        input  Mdu_Valid, Mdu_Reg, Mdu_Data,
        input  Issue_Valid, Issue_Reg, Rs, Rt,
        output Mdu_Ready, Rs_Busy, Rt_Busy,
        output Reg_Wb, WriteData, Write
`ifdef WB_BYPASS_EN
        , output Fwd_Rs_Hit, Fwd_Rt_Hit, Fwd_Data
`endif
    );

    // Pipeline / decode / register-file side
    modport master (
        output Alu_Valid, Alu_Reg, Alu_Data,
        output Mdu_Valid, Mdu_Reg, Mdu_Data,
        output Issue_Valid, Issue_Reg, Rs, Rt,
        input  Mdu_Ready, Rs_Busy, Rt_Busy,
        input  Reg_Wb, WriteData, Write
`ifdef WB_BYPASS_EN
        , input Fwd_Rs_Hit, Fwd_Rt_Hit, Fwd_Data
`endif
    );

endinterface
`default_nettype wire

// File: rtl/reg_writeback_arbiter_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_result_fifo                                                |
// | Description : DEPTH-entry FIFO holding MDU results waiting for the write    |
// |               port. Head is presented combinationally on o_data.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_push,
    input  wire logic [W-1:0] i_data,
    input  wire logic         i_pop,
    output logic      [W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + c_PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/reg_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_writeback_arbiter                                         |
// | Description : Merges ALU and MDU results onto the register-file write port  |
// |               and tracks in-flight MDU destinations. Macro: WB_BYPASS_EN.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module reg_writeback_arbiter
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = c_AW,
    parameter int DW    = c_DW
) (
    input  wire logic              Clk,
    input  wire logic              Rst,
    reg_writeback_arbiter_if.slave bus
);

    localparam int            c_EW   = AW + DW;
    localparam logic [AW-1:0] c_ZERO = AW'(c_REG_ZERO);

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [c_EW-1:0] w_head;
    logic [AW-1:0] w_head_reg;
    logic [DW-1:0] w_head_data;

    logic          r_write;
    logic [AW-1:0] r_reg;
    logic [DW-1:0] r_data;
    wb_src_e       r_src;

    logic [2**AW-1:0] r_sb;
    logic [2**AW-1:0] w_sb_next;
    logic             w_rs_pend;
    logic             w_rt_pend;

    assign {w_head_reg, w_head_data} = w_head;
    assign w_push = bus.Mdu_Valid & ~w_full;
    // ALU owns the port whenever it is valid; the MDU head simply waits
    assign w_pop  = ~bus.Alu_Valid & ~w_empty;

    wb_result_fifo #(
        .DEPTH (DEPTH),
        .W     (c_EW)
    ) u_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .i_push  (w_push),
        .i_data  ({bus.Mdu_Reg, bus.Mdu_Data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_write <= 1'b0;
            r_reg   <= '0;
            r_data  <= '0;
            r_src   <= SRC_ALU;
        end else if (bus.Alu_Valid) begin
            r_write <= (bus.Alu_Reg != c_ZERO);
            r_reg   <= bus.Alu_Reg;
            r_data  <= bus.Alu_Data;
            r_src   <= SRC_ALU;
        end else if (w_pop) begin
            r_write <= (w_head_reg != c_ZERO);
            r_reg   <= w_head_reg;
            r_data  <= w_head_data;
            r_src   <= SRC_MDU;
        end else begin
            r_write <= 1'b0;
        end
    end

    // Clear first, then set, so a re-issue on the landing edge keeps the bit
    always_comb begin
        w_sb_next = r_sb;
        if (r_write && (r_src == SRC_MDU)) begin
            w_sb_next[r_reg] = 1'b0;
        end
        if (bus.Issue_Valid && (bus.Issue_Reg != c_ZERO)) begin
            w_sb_next[bus.Issue_Reg] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    assign w_rs_pend     = r_sb[bus.Rs] & (bus.Rs != c_ZERO);
    assign w_rt_pend     = r_sb[bus.Rt] & (bus.Rt != c_ZERO);
    assign bus.Mdu_Ready = ~w_full;
    assign bus.Reg_Wb    = r_reg;
    assign bus.WriteData = r_data;
    assign bus.Write     = r_write;

`ifdef WB_BYPASS_EN
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit       = r_write & (r_reg == bus.Rs) & (bus.Rs != c_ZERO);
    assign w_rt_hit       = r_write & (r_reg == bus.Rt) & (bus.Rt != c_ZERO);
    assign bus.Fwd_Rs_Hit = w_rs_hit;
    assign bus.Fwd_Rt_Hit = w_rt_hit;
    assign bus.Fwd_Data   = r_data;
    // A landing MDU write can be forwarded, so its pending bit no longer stalls
    assign bus.Rs_Busy    = w_rs_pend & ~(w_rs_hit & (r_src == SRC_MDU));
    assign bus.Rt_Busy    = w_rt_pend & ~(w_rt_hit & (r_src == SRC_MDU));
`else
    assign bus.Rs_Busy    = w_rs_pend;
    assign bus.Rt_Busy    = w_rt_pend;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge Clk) begin
        if (!Rst && bus.Alu_Valid && (bus.Alu_Reg != c_ZERO)) begin
            assert (!r_sb[bus.Alu_Reg])
                else $error("ALU write to pending register %0d", bus.Alu_Reg);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_writeback_arbiter                                      |
// | Description : Directed and randomized bench for reg_writeback_arbiter.      |
// |               Honors WB_BYPASS_EN.                                          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_reg_writeback_arbiter;
    import reg_writeback_arbiter_pkg::*;

    localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    reg_writeback_arbiter_if bus ();

    reg_writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO as a queue, pending set as a bit array
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    bit          m_pend[32];
    bit          m_write;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_from_mdu;

    function automatic void model_edge();
        bit   accept;
        ent_t e;
        if (Rst) begin
            m_q.delete();
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_write = 1'b0; m_reg = '0; m_data = '0; m_from_mdu = 1'b0;
            return;
        end
        accept = bus.Mdu_Valid && (m_q.size() != DEPTH);
        if (m_write && m_from_mdu) m_pend[m_reg] = 1'b0;
        if (bus.Issue_Valid && bus.Issue_Reg != 5'd0) m_pend[bus.Issue_Reg] = 1'b1;
        if (bus.Alu_Valid) begin
            m_write = (bus.Alu_Reg != 5'd0); m_reg = bus.Alu_Reg;
            m_data = bus.Alu_Data; m_from_mdu = 1'b0;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_write = (e.r != 5'd0); m_reg = e.r; m_data = e.d; m_from_mdu = 1'b1;
        end else begin
            m_write = 1'b0;
        end
        if (accept) begin
            e.r = bus.Mdu_Reg; e.d = bus.Mdu_Data;
            m_q.push_back(e);
        end
    endfunction

    function automatic bit exp_busy(logic [4:0] r);
        return m_pend[r] && (r != 5'd0) &&
               !(c_BYP && m_write && m_from_mdu && (m_reg == r));
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.Alu_Valid = 1'b0; bus.Alu_Reg = '0; bus.Alu_Data = '0;
        bus.Mdu_Valid = 1'b0; bus.Mdu_Reg = '0; bus.Mdu_Data = '0;
        bus.Issue_Valid = 1'b0; bus.Issue_Reg = '0;
        bus.Rs = '0; bus.Rt = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.Alu_Valid = 1'b1; bus.Alu_Reg = 5'd1; bus.Alu_Data = 32'h11;
        bus.Issue_Valid = 1'b1; bus.Issue_Reg = 5'd4;
        tick();
        bus.Issue_Valid = 1'b0; bus.Alu_Reg = 5'd2;
        bus.Mdu_Valid = 1'b1; bus.Mdu_Reg = 5'd4; bus.Mdu_Data = 32'h44;
        tick();
        bus.Mdu_Valid = 1'b0; bus.Alu_Reg = 5'd3; bus.Rs = 5'd4;
        #1;
        n_checks++;
        if (bus.Rs_Busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %0b exp 1", bus.Rs_Busy); end
        Rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.Write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %0b exp 0", bus.Write); end
        n_checks++;
        if (bus.Reg_Wb !== 5'd0) begin n_fail++; $display("FAIL reset_reg_wb: got %0d exp 0", bus.Reg_Wb); end
        n_checks++;
        if (bus.WriteData !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h exp 0", bus.WriteData); end
        n_checks++;
        if (bus.Mdu_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b exp 1", bus.Mdu_Ready); end
        idle();
        Rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.Rs = 5'(i); bus.Rt = 5'(31 - i);
            #1;
            n_checks++;
            if (bus.Rs_Busy !== 1'b0 || bus.Rt_Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy[%0d]: got rs=%0b rt=%0b exp 0", i, bus.Rs_Busy, bus.Rt_Busy);
            end
        end
        idle();
        tick();
        n_checks++;
        if (bus.Write !== 1'b0) begin n_fail++; $display("FAIL reset_discard: got write=%0b exp 0", bus.Write); end
    endtask

    task automatic test_alu_only();
        idle();
        bus.Alu_Valid = 1'b1; bus.Alu_Reg = 5'd3; bus.Alu_Data = 32'h1234;
        tick();
        n_checks++;
        if (bus.Write !== 1'b1 || bus.Reg_Wb !== 5'd3 || bus.WriteData !== 32'h1234) begin
            n_fail++;
            $display("FAIL alu_r3: got w=%0b r=%0d d=%0h exp w=1 r=3 d=1234", bus.Write, bus.Reg_Wb, bus.WriteData);
        end
        bus.Alu_Reg = 5'd0; bus.Alu_Data = 32'hFFFF;
        tick();
        n_checks++;
        if (bus.Write !== 1'b0) begin n_fail++; $display("FAIL alu_r0: got write=%0b exp 0", bus.Write); end
        idle();
        tick();
        n_checks++;
        if (bus.Write !== 1'b0) begin n_fail++; $display("FAIL alu_idle: got write=%0b exp 0", bus.Write); end
    endtask

    task automatic test_contention();
        idle();
        bus.Issue_Valid = 1'b1; bus.Issue_Reg = 5'd5;
        tick();
        bus.Issue_Valid = 1'b0; bus.Rs = 5'd5;
        #1;
        n_checks++;
        if (bus.Rs_Busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy_issue: got %0b exp 1", bus.Rs_Busy); end
        for (int i = 0; i < 3; i++) begin
            bus.Alu_Valid = 1'b1; bus.Alu_Reg = 5'd10; bus.Alu_Data = 32'hA0 + 32'(i);
            bus.Mdu_Valid = (i == 0); bus.Mdu_Reg = 5'd5; bus.Mdu_Data = 32'hDEAD;
            tick();
            n_checks++;
            if (bus.Write !== 1'b1 || bus.Reg_Wb !== 5'd10 || bus.WriteData !== 32'hA0 + 32'(i) || bus.Rs_Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL cont_alu[%0d]: got w=%0b r=%0d d=%0h busy=%0b exp w=1 r=10 d=%0h busy=1",
                         i, bus.Write, bus.Reg_Wb, bus.WriteData, bus.Rs_Busy, 32'hA0 + i);
            end
        end
        bus.Alu_Valid = 1'b0; bus.Mdu_Valid = 1'b0;
        tick();
        n_checks++;
        if (bus.Write !== 1'b1 || bus.Reg_Wb !== 5'd5 || bus.WriteData !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL cont_mdu: got w=%0b r=%0d d=%0h exp w=1 r=5 d=dead", bus.Write, bus.Reg_Wb, bus.WriteData);
        end
        n_checks++;
        if (bus.Rs_Busy !== !c_BYP) begin n_fail++; $display("FAIL cont_busy_land: got %0b exp %0b", bus.Rs_Busy, !c_BYP); end
        tick();
        n_checks++;
        if (bus.Write !== 1'b0 || bus.Rs_Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_after: got w=%0b busy=%0b exp 0 0", bus.Write, bus.Rs_Busy);
        end
    endtask

    task automatic test_full();
        idle();
        bus.Issue_Valid = 1'b1; bus.Issue_Reg = 5'd6;
        tick();
        bus.Issue_Reg = 5'd7;
        tick();
        bus.Issue_Valid = 1'b0;
        bus.Alu_Valid = 1'b1; bus.Alu_Reg = 5'd11; bus.Alu_Data = 32'hB0;
        bus.Mdu_Valid = 1'b1; bus.Mdu_Reg = 5'd6; bus.Mdu_Data = 32'h66;
        #1;
        n_checks++;
        if (bus.Mdu_Ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_init: got %0b exp 1", bus.Mdu_Ready); end
        tick();
        bus.Mdu_Reg = 5'd7; bus.Mdu_Data = 32'h77; bus.Alu_Data = 32'hB1;
        tick();
        bus.Mdu_Valid = 1'b0; bus.Alu_Data = 32'hB2;
        #1;
        n_checks++;
        if (bus.Mdu_Ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %0b exp 0", bus.Mdu_Ready); end
        tick();
        n_checks++;
        if (bus.Mdu_Ready !== 1'b0 || bus.Write !== 1'b1 || bus.Reg_Wb !== 5'd11) begin
            n_fail++;
            $display("FAIL full_hold: got rdy=%0b w=%0b r=%0d exp 0 1 11", bus.Mdu_Ready, bus.Write, bus.Reg_Wb);
        end
        bus.Alu_Valid = 1'b0;
        tick();
        n_checks++;
        if (bus.Write !== 1'b1 || bus.Reg_Wb !== 5'd6 || bus.WriteData !== 32'h66 || bus.Mdu_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop6: got w=%0b r=%0d d=%0h rdy=%0b exp 1 6 66 1", bus.Write, bus.Reg_Wb, bus.WriteData, bus.Mdu_Ready);
        end
        tick();
        n_checks++;
        if (bus.Write !== 1'b1 || bus.Reg_Wb !== 5'd7 || bus.WriteData !== 32'h77) begin
            n_fail++;
            $display("FAIL full_pop7: got w=%0b r=%0d d=%0h exp 1 7 77", bus.Write, bus.Reg_Wb, bus.WriteData);
        end
        tick();
        n_checks++;
        if (bus.Write !== 1'b0) begin n_fail++; $display("FAIL full_drained: got write=%0b exp 0", bus.Write); end
    endtask

    task automatic test_same_edge();
        idle();
        bus.Issue_Valid = 1'b1; bus.Issue_Reg = 5'd8;
        tick();
        bus.Issue_Valid = 1'b0;
        bus.Mdu_Valid = 1'b1; bus.Mdu_Reg = 5'd8; bus.Mdu_Data = 32'h88;
        tick();
        bus.Mdu_Valid = 1'b0;
        tick();
        n_checks++;
        if (bus.Write !== 1'b1 || bus.Reg_Wb !== 5'd8) begin
            n_fail++;
            $display("FAIL same_land: got w=%0b r=%0d exp 1 8", bus.Write, bus.Reg_Wb);
        end
        bus.Issue_Valid = 1'b1; bus.Issue_Reg = 5'd8; bus.Rt = 5'd8;
        tick();
        bus.Issue_Valid = 1'b0;
        #1;
        n_checks++;
        if (bus.Rt_Busy !== 1'b1) begin n_fail++; $display("FAIL same_edge_busy: got %0b exp 1", bus.Rt_Busy); end
        bus.Mdu_Valid = 1'b1; bus.Mdu_Data = 32'h89;
        tick();
        bus.Mdu_Valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.Rt_Busy !== 1'b0) begin n_fail++; $display("FAIL same_cleared: got %0b exp 0", bus.Rt_Busy); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        idle();
        bus.Issue_Valid = 1'b1; bus.Issue_Reg = 5'd9;
        tick();
        bus.Issue_Valid = 1'b0;
        bus.Mdu_Valid = 1'b1; bus.Mdu_Reg = 5'd9; bus.Mdu_Data = 32'h55;
        tick();
        bus.Mdu_Valid = 1'b0;
        tick();
        bus.Rs = 5'd9; bus.Rt = 5'd9;
        #1;
        n_checks++;
        if (bus.Fwd_Rs_Hit !== 1'b1 || bus.Fwd_Rt_Hit !== 1'b1 || bus.Fwd_Data !== 32'h55 || bus.Rs_Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL byp_hit: got rs=%0b rt=%0b d=%0h busy=%0b exp 1 1 55 0",
                     bus.Fwd_Rs_Hit, bus.Fwd_Rt_Hit, bus.Fwd_Data, bus.Rs_Busy);
        end
        tick();
        n_checks++;
        if (bus.Fwd_Rs_Hit !== 1'b0) begin n_fail++; $display("FAIL byp_after: got %0b exp 0", bus.Fwd_Rs_Hit); end
    endtask
`endif

    task automatic test_random();
        logic [4:0] iq[$];
        bit         offering = 1'b0;
        bit         accept;
        bit         issued;
        logic [4:0] r;
        idle();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.Issue_Valid = 1'b0;
            if (!offering) begin
                if (iq.size() > 0 && $urandom_range(1, 0) == 1) begin
                    offering = 1'b1; bus.Mdu_Reg = iq[0]; bus.Mdu_Data = $urandom;
                end else if (iq.size() == 0 && $urandom_range(7, 0) == 0) begin
                    offering = 1'b1; bus.Mdu_Reg = 5'd0; bus.Mdu_Data = $urandom;
                end
            end
            bus.Mdu_Valid = offering;
            if ($urandom_range(3, 0) == 0) begin
                r = 5'($urandom_range(31, 0));
                if (!m_pend[r]) begin
                    bus.Issue_Valid = 1'b1; bus.Issue_Reg = r;
                end
            end
            bus.Alu_Valid = ($urandom_range(1, 0) == 1);
            r = 5'($urandom_range(31, 0));
            while (m_pend[r]) r = 5'($urandom_range(31, 0));
            bus.Alu_Reg = r; bus.Alu_Data = $urandom;
            bus.Rs = 5'($urandom_range(31, 0));
            bus.Rt = 5'($urandom_range(31, 0));
            #1;
            n_checks++;
            if (bus.Mdu_Ready !== (m_q.size() != DEPTH)) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %0b exp %0b", cyc, bus.Mdu_Ready, m_q.size() != DEPTH);
            end
            n_checks++;
            if (bus.Rs_Busy !== exp_busy(bus.Rs) || bus.Rt_Busy !== exp_busy(bus.Rt)) begin
                n_fail++;
                $display("FAIL rnd_busy[%0d]: got rs=%0b rt=%0b exp rs=%0b rt=%0b",
                         cyc, bus.Rs_Busy, bus.Rt_Busy, exp_busy(bus.Rs), exp_busy(bus.Rt));
            end
`ifdef WB_BYPASS_EN
            n_checks++;
            if (bus.Fwd_Rs_Hit !== (m_write && m_reg == bus.Rs && bus.Rs != 5'd0)) begin
                n_fail++; $display("FAIL rnd_fwd[%0d]: got %0b", cyc, bus.Fwd_Rs_Hit);
            end
`endif
            accept = offering && (m_q.size() != DEPTH);
            issued = bus.Issue_Valid && (bus.Issue_Reg != 5'd0);
            tick();
            if (accept) begin
                offering = 1'b0;
                if (bus.Mdu_Reg != 5'd0) void'(iq.pop_front());
            end
            if (issued) iq.push_back(bus.Issue_Reg);
            n_checks++;
            if (bus.Write !== m_write || (m_write && (bus.Reg_Wb !== m_reg || bus.WriteData !== m_data))) begin
                n_fail++;
                $display("FAIL rnd_wb[%0d]: got w=%0b r=%0d d=%0h exp w=%0b r=%0d d=%0h",
                         cyc, bus.Write, bus.Reg_Wb, bus.WriteData, m_write, m_reg, m_data);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        test_reset();
        test_alu_only();
        test_contention();
        test_full();
        test_same_edge();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
